// File: rtl/master_tx_ltssm.sv
// TX-side LTSSM substate sequencer: commands the ordered-set type per substate, counts sent sets
// and reports completion to the main LTSSM. Optional EIEOS insertion: define TX_EIEOS_EN.
// Handshake: osSent, rxDone and detectDone are single-cycle pulses sampled on clk; sendOs is a level
// held high for as long as osType is being requested, and finish is a one-cycle pulse qualified by success.
module master_tx_ltssm #(
  parameter int MAXLANES        = 16,
  parameter int POLL_TS1_COUNT  = 1024,
  parameter int TS2_POST_COUNT  = 16,
  parameter int IDLE_POST_COUNT = 16,
  parameter int COUNT_W         = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          substate,
  input  logic [4:0]          numberOfDetectedLanes,
  input  logic                osSent,
  input  logic                rxDone,
  input  logic                detectDone,
  input  logic                timeOut,
  output logic                sendOs,
  output logic [2:0]          osType,
  output logic                txElectricalIdle,
  output logic                detectReq,
  output logic [MAXLANES-1:0] laneEnable,
  output logic                finish,
  output logic                success,
  output logic [3:0]          exitTo,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {S_START, S_LOAD, S_SEND, S_POST, S_DONE, S_FAIL} state_t;

  localparam logic [2:0] OS_NONE  = 3'd0;
  localparam logic [2:0] OS_TS1   = 3'd1;
  localparam logic [2:0] OS_TS2   = 3'd2;
  localparam logic [2:0] OS_IDLE  = 3'd3;
  localparam logic [2:0] OS_EIEOS = 3'd4;

  state_t             state;
  logic [3:0]         cur_sub;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] cnt_next;
  logic               rx_seen;
  logic               counted_pulse;
  logic               seq_done;
  logic               post_done;
  logic               to_post;

  assign state_dbg = state;

  function automatic logic [2:0] base_type(input logic [3:0] s);
    case (s)
      4'd2, 4'd4, 4'd5, 4'd6, 4'd7: base_type = OS_TS1;
      4'd3, 4'd8:                   base_type = OS_TS2;
      4'd9:                         base_type = OS_IDLE;
      default:                      base_type = OS_NONE;
    endcase
  endfunction

  function automatic logic [MAXLANES-1:0] lane_mask(input logic [4:0] w);
    logic ok;
    ok = (w == 5'd1) || (w == 5'd2) || (w == 5'd4) || (w == 5'd8) || (w == 5'd16);
    for (int i = 0; i < MAXLANES; i++) lane_mask[i] = ok && (i < int'(w));
  endfunction

`ifdef TX_EIEOS_EN
  logic [4:0] eie_cnt;
  logic       eie_en;
  // The EIEOS itself is not a counted TS1/TS2.
  assign counted_pulse = osSent && (osType != OS_EIEOS);
  assign eie_en        = (cur_sub >= 4'd2) && (cur_sub <= 4'd8);
`else
  assign counted_pulse = osSent;
`endif

  assign cnt_next = counted_pulse ? ((&count) ? count : count + COUNT_W'(1)) : count;
  assign to_post  = rxDone && ((cur_sub == 4'd3) || (cur_sub == 4'd8) || (cur_sub == 4'd9));

  always_comb begin
    seq_done = 1'b0;
    case (cur_sub)
      4'd0, 4'd4, 4'd5, 4'd6, 4'd7: seq_done = rxDone;
      4'd1:                         seq_done = detectDone;
      4'd2: seq_done = (cnt_next >= COUNT_W'(POLL_TS1_COUNT)) && (rx_seen || rxDone);
      default:                      seq_done = 1'b0;
    endcase
    post_done = (cur_sub == 4'd9) ? (cnt_next >= COUNT_W'(IDLE_POST_COUNT))
                                  : (cnt_next >= COUNT_W'(TS2_POST_COUNT));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_START;
      cur_sub          <= 4'hF;
      count            <= '0;
      rx_seen          <= 1'b0;
      sendOs           <= 1'b0;
      osType           <= OS_NONE;
      txElectricalIdle <= 1'b1;
      detectReq        <= 1'b0;
      laneEnable       <= '0;
      finish           <= 1'b0;
      success          <= 1'b0;
      exitTo           <= 4'd0;
`ifdef TX_EIEOS_EN
      eie_cnt          <= '0;
`endif
    end else begin
      finish    <= 1'b0;
      success   <= 1'b0;
      exitTo    <= 4'd0;
      detectReq <= 1'b0;
      case (state)
        S_START: begin
          sendOs <= 1'b0;
          if (substate != cur_sub) begin
            cur_sub    <= substate;
            laneEnable <= lane_mask(numberOfDetectedLanes);
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          count            <= '0;
          rx_seen          <= 1'b0;
          osType           <= base_type(cur_sub);
          sendOs           <= (base_type(cur_sub) != OS_NONE);
          txElectricalIdle <= (cur_sub <= 4'd1);
          detectReq        <= (cur_sub == 4'd1);
`ifdef TX_EIEOS_EN
          eie_cnt          <= '0;
`endif
          state            <= S_SEND;
        end
        S_SEND, S_POST: begin
          if (substate != cur_sub) begin
            // Substate moved under us: drop this sequence silently and reload.
            cur_sub    <= substate;
            laneEnable <= lane_mask(numberOfDetectedLanes);
            sendOs     <= 1'b0;
            state      <= S_LOAD;
          end else if (timeOut) begin
            finish           <= 1'b1;
            success          <= 1'b0;
            exitTo           <= 4'd0;
            txElectricalIdle <= 1'b1;
            sendOs           <= 1'b0;
            state            <= S_FAIL;
          end else begin
            count   <= cnt_next;
            rx_seen <= rx_seen | rxDone;
`ifdef TX_EIEOS_EN
            if (osSent) begin
              if (osType == OS_EIEOS) begin
                osType <= base_type(cur_sub);
              end else if (eie_en) begin
                if (eie_cnt == 5'd31) begin
                  eie_cnt <= '0;
                  osType  <= OS_EIEOS;
                end else begin
                  eie_cnt <= eie_cnt + 5'd1;
                end
              end
            end
`endif
            if (state == S_SEND && to_post) begin
              // A set finishing alongside rxDone is the first post-rx set.
              count <= osSent ? COUNT_W'(1) : '0;
              state <= S_POST;
`ifdef TX_EIEOS_EN
              osType  <= base_type(cur_sub);
              eie_cnt <= '0;
`endif
            end else if ((state == S_SEND && seq_done) || (state == S_POST && post_done)) begin
              finish  <= 1'b1;
              success <= 1'b1;
              exitTo  <= cur_sub + 4'd1;
              sendOs  <= 1'b0;
              state   <= S_DONE;
            end
          end
        end
        S_DONE, S_FAIL: begin
          sendOs <= 1'b0;
          state  <= S_START;
        end
        default: state <= S_START;
      endcase
    end
  end

endmodule

// File: tb/tb_master_tx_ltssm.sv
// Randomized scoreboard bench for master_tx_ltssm: a per-sequence model predicts the finish cycle
// and result, and a negedge monitor pops and compares whenever finish is presented.
`timescale 1ns/1ps
module tb_master_tx_ltssm;
  localparam int L_MAX = 1400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  substate = 4'd0;
  logic [4:0]  nodl = 5'd16;
  logic        osSent = 1'b0, rxDone = 1'b0, detectDone = 1'b0, timeOut = 1'b0;
  logic        sendOs, txElectricalIdle, detectReq, finish, success;
  logic [2:0]  osType, state_dbg;
  logic [15:0] laneEnable;
  logic [3:0]  exitTo;

  master_tx_ltssm dut (
    .clk(clk), .reset(reset), .substate(substate), .numberOfDetectedLanes(nodl),
    .osSent(osSent), .rxDone(rxDone), .detectDone(detectDone), .timeOut(timeOut),
    .sendOs(sendOs), .osType(osType), .txElectricalIdle(txElectricalIdle),
    .detectReq(detectReq), .laneEnable(laneEnable), .finish(finish), .success(success),
    .exitTo(exitTo), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        ok;
    logic [3:0]  exit_to;
    logic [31:0] fin_cyc;
    logic [15:0] lane_en;
    logic        tx_idle;
    logic [7:0]  det_cnt;
    logic [31:0] det_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  bit   os_a[L_MAX];
  bit   rx_a[L_MAX];
  bit   dd_a[L_MAX];
  bit   to_a[L_MAX];
  bit   slot_active = 1'b0;
  logic exp_send = 1'b0;
  logic [2:0] exp_os = 3'd0;
  bit   os_bad = 1'b0;
  int   det_cnt = 0;
  int   det_cyc = -1;
  int   change_cyc = 0;
  int   prev_sub = 2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
  endtask

  // reference model
  function automatic logic [2:0] base_os(input int sub);
    case (sub)
      2, 4, 5, 6, 7: return 3'd1;
      3, 8:          return 3'd2;
      9:             return 3'd3;
      default:       return 3'd0;
    endcase
  endfunction

  function automatic int counted(input int n, input int sub);
`ifdef TX_EIEOS_EN
    if (sub >= 2 && sub <= 8) return n - n / 33;
`endif
    return n;
  endfunction

  function automatic logic [15:0] lane_exp(input int w);
    if (w == 1 || w == 2 || w == 4 || w == 8 || w == 16) return 16'((32'h1 << w) - 1);
    return 16'h0;
  endfunction

  function automatic void model(input int sub, input int len, output int fin, output bit ok);
    int  pulses = 0;
    int  post = -1;
    bit  seen = 0;
    fin = len - 1;
    ok  = 0;
    for (int i = 0; i < len; i++) begin
      if (to_a[i]) begin fin = i; ok = 0; return; end
      pulses += int'(os_a[i]);
      if (rx_a[i]) seen = 1;
      case (sub)
        0, 4, 5, 6, 7: if (rx_a[i]) begin fin = i; ok = 1; return; end
        1:             if (dd_a[i]) begin fin = i; ok = 1; return; end
        2: if (seen && counted(pulses, sub) >= 1024) begin fin = i; ok = 1; return; end
        default: begin
          if (post < 0) begin
            if (rx_a[i]) post = int'(os_a[i]);
          end else begin
            post += int'(os_a[i]);
            if (counted(post, sub) >= 16) begin fin = i; ok = 1; return; end
          end
        end
      endcase
    end
  endfunction

  // driver tasks
  task automatic gen(input int sub, input int mode, output int len);
    int rx_slot;
    for (int i = 0; i < L_MAX; i++) begin
      os_a[i] = 0; rx_a[i] = 0; dd_a[i] = 0; to_a[i] = 0;
    end
    if (sub == 2) begin
      len = L_MAX;
      rx_slot = $urandom_range(0, 1300);
      for (int i = 0; i < len; i++) os_a[i] = ($urandom_range(0, 15) != 0);
    end else begin
      len = 80;
      rx_slot = $urandom_range(0, 30);
      for (int i = 0; i < len; i++) os_a[i] = ($urandom_range(0, 3) != 0);
      dd_a[$urandom_range(0, 40)] = 1;
    end
    rx_a[rx_slot] = 1;
    if (mode == 1) to_a[rx_slot] = 1;
    if (mode == 2) os_a[rx_slot] = 1;
    if (mode == 0 && $urandom_range(0, 4) == 0) to_a[$urandom_range(0, len - 1)] = 1;
    to_a[len - 1] = 1;
  endtask

  task automatic start_seq(input int sub, input int lanes);
    @(posedge clk); #1;
    substate   = 4'(sub);
    nodl       = 5'(lanes);
    reset      = 1'b1;
    change_cyc = cyc;
    det_cnt    = 0;
    det_cyc    = -1;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic drive_slots(input int sub, input int last);
    int n = 0;
    bit post = 0;
    for (int i = 0; i <= last; i++) begin
      osSent = os_a[i]; rxDone = rx_a[i]; detectDone = dd_a[i]; timeOut = to_a[i];
      exp_send = (base_os(sub) != 3'd0);
      exp_os   = base_os(sub);
`ifdef TX_EIEOS_EN
      if (sub >= 2 && sub <= 8 && (n % 33) == 32) exp_os = 3'd4;
`endif
      slot_active = 1'b1;
      @(posedge clk); #1;
      if ((sub == 3 || sub == 8 || sub == 9) && !post && rx_a[i]) begin
        post = 1; n = int'(os_a[i]);
      end else begin
        n += int'(os_a[i]);
      end
    end
    slot_active = 1'b0;
    osSent = 0; rxDone = 0; detectDone = 0; timeOut = 0;
  endtask

  task automatic run_seq(input int sub, input int lanes, input int mode);
    int   len, fin, base;
    bit   ok;
    exp_t e;
    gen(sub, mode, len);
    model(sub, len, fin, ok);
    start_seq(sub, lanes);
    base      = cyc;
    e.ok      = ok;
    e.exit_to = ok ? 4'(sub + 1) : 4'd0;
    e.fin_cyc = base + fin + 1;
    e.lane_en = lane_exp(lanes);
    e.tx_idle = ok ? (sub <= 1) : 1'b1;
    e.det_cnt = (sub == 1) ? 8'd1 : 8'd0;
    e.det_cyc = (sub == 1) ? change_cyc + 2 : -1;
    exp_q.push_back(e);
    drive_slots(sub, fin);
    repeat (2) @(posedge clk);
    prev_sub = sub;
  endtask

  task automatic run_abandon(input int sub, input int lanes, input int k);
    for (int i = 0; i < L_MAX; i++) begin
      os_a[i] = 0; rx_a[i] = 0; dd_a[i] = 0; to_a[i] = 0;
    end
    for (int i = 0; i < k; i++) os_a[i] = $urandom_range(0, 1);
    start_seq(sub, lanes);
    drive_slots(sub, k - 1);
    prev_sub = sub;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      if (detectReq) begin
        det_cnt++;
        if (det_cyc < 0) det_cyc = cyc;
      end
      if (slot_active && (sendOs !== exp_send || osType !== exp_os)) os_bad = 1'b1;
      if (finish) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_finish", 32'(finish), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("finish_cycle", cyc, mon_e.fin_cyc);
          chk("success", 32'(success), 32'(mon_e.ok));
          chk("exit_to", 32'(exitTo), 32'(mon_e.exit_to));
          chk("tx_idle", 32'(txElectricalIdle), 32'(mon_e.tx_idle));
          chk("lane_enable", 32'(laneEnable), 32'(mon_e.lane_en));
          chk("send_os_dropped", 32'(sendOs), 32'd0);
          chk("os_type_during_seq", 32'(os_bad), 32'd0);
          chk("detect_req_count", det_cnt, 32'(mon_e.det_cnt));
          chk("detect_req_cycle", det_cyc, mon_e.det_cyc);
          os_bad = 1'b0;
        end
      end
    end
  end

  initial begin
    int sub, lanes;
    int lane_tab[6] = '{1, 2, 4, 8, 16, 3};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_send_os", 32'(sendOs), 32'd0);
    chk("rst_os_type", 32'(osType), 32'd0);
    chk("rst_tx_idle", 32'(txElectricalIdle), 32'd1);
    chk("rst_detect_req", 32'(detectReq), 32'd0);
    chk("rst_lane_enable", 32'(laneEnable), 32'd0);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_success", 32'(success), 32'd0);
    chk("rst_exit_to", 32'(exitTo), 32'd0);

    run_seq(2, 16, 3);
    run_seq(3, 8, 2);
    run_seq(1, 2, 3);
    run_seq(4, 1, 1);
    run_seq(9, 4, 3);
    run_seq(0, 16, 3);
    run_abandon(5, 16, 10);
    run_seq(6, 16, 3);
    run_abandon(1, 8, 6);
    run_seq(8, 3, 2);

    for (int t = 0; t < 24; t++) begin
      do sub = $urandom_range(0, 9); while (sub == prev_sub);
      lanes = lane_tab[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0) run_abandon(sub, lanes, $urandom_range(1, 20));
      else run_seq(sub, lanes, $urandom_range(0, 3));
    end

    repeat (4) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    // asynchronous reset in the middle of a sequence
    do sub = $urandom_range(2, 9); while (sub == prev_sub);
    run_abandon(sub, 16, 5);
    #2 reset = 1'b0;
    #1;
    chk("arst_send_os", 32'(sendOs), 32'd0);
    chk("arst_os_type", 32'(osType), 32'd0);
    chk("arst_tx_idle", 32'(txElectricalIdle), 32'd1);
    chk("arst_lane_enable", 32'(laneEnable), 32'd0);
    chk("arst_finish", 32'(finish), 32'd0);
    chk("arst_exit_to", 32'(exitTo), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
